// File: rtl/interrupt_controller_pkg.sv
// Shared types for the cpu32e2 interrupt controller: register map, FSM encodings
// and the nesting-mask helper.
package intcPkg;

  localparam int NUM_IDS = 16;

  typedef enum logic [2:0] {
    REG_PENDING    = 3'd0,
    REG_ENABLE     = 3'd1,
    REG_EDGE       = 3'd2,
    REG_IN_SERVICE = 3'd3,
    REG_EOI        = 3'd4,
    REG_STATUS     = 3'd5
  } reg_idx_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } req_state_e;

  typedef enum logic {
    BUS_IDLE  = 1'b0,
    READ_RESP = 1'b1
  } bus_state_e;

  // Mask of indices strictly below the lowest set bit; all ones when nothing is set.
  function automatic logic [NUM_IDS-1:0] below_lowest(input logic [NUM_IDS-1:0] v);
    logic [NUM_IDS-1:0] lowest;
    lowest = v & (~v + 16'd1);
    if (v == 16'd0) begin
      below_lowest = 16'hFFFF;
    end else begin
      below_lowest = lowest - 16'd1;
    end
  endfunction

endpackage

// File: rtl/intc_priority_select.sv
// Find-first-set over the eligible mask; index 0 has the highest priority.
module intc_priority_select
  import intcPkg::*;
(
  input  logic [NUM_IDS-1:0] eligible,
  output logic               valid,
  output logic [3:0]         id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = 4'd0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      valid = valid | eligible[i];
      id    = eligible[i] ? 4'(i) : id;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: synchronises and latches external lines,
// selects the highest-priority eligible source and runs the CPU request handshake.
module interrupt_controller
  import intcPkg::*;
#(
  parameter int          NUM_SOURCES  = 16,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] BASE_ADDRESS = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  bwe,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  output logic        waitRequest,
  output logic        readValid,
  output logic [31:0] dataOut,
  input  logic [15:0] irqSource,
  output logic        interruptRequest,
  output logic [3:0]  interruptIn,
  input  logic        interruptAcknowledge,
  input  logic [3:0]  interruptOut
);

  localparam logic [NUM_IDS-1:0] IMPL_MASK = 16'((33'd1 << NUM_SOURCES) - 33'd1);

  logic [NUM_IDS-1:0] sync_r [SYNC_STAGES];
  logic [NUM_IDS-1:0] prev_r;
  logic [NUM_IDS-1:0] pending_r, enable_r, edge_r, in_service_r;
  logic [NUM_IDS-1:0] pending_next_s, enable_next_s, edge_next_s, in_service_next_s;
  req_state_e         req_state_r, req_next_s;
  bus_state_e         bus_state_r, bus_next_s;
  logic [3:0]         int_id_r, id_next_s;
  logic               req_r, read_valid_r;
  logic [31:0]        data_out_r;

  logic               hit_s, wait_s, wr_s, rd_s, ack_s;
  reg_idx_e           reg_idx_s;
  logic [NUM_IDS-1:0] synced_s, rise_s, byte_mask_s, wdata_s, w1c_s;
  logic [NUM_IDS-1:0] ack_onehot_s, eoi_onehot_s, eligible_s;
  logic [15:0]        rd_data_s;
  logic               sel_valid_s;
  logic [3:0]         sel_id_s;
  logic               unused_s;

  assign unused_s = ^{bwe[3:2], address[1:0], dataIn[31:16]};

  assign hit_s       = (address[31:5] == BASE_ADDRESS[31:5]);
  assign reg_idx_s   = reg_idx_e'(address[4:2]);
  assign wait_s      = hit_s & (read | write) & (bus_state_r == READ_RESP);
  assign wr_s        = hit_s & write & (bus_state_r == BUS_IDLE);
  assign rd_s        = hit_s & read & ~write & (bus_state_r == BUS_IDLE);
  assign byte_mask_s = {{8{bwe[1]}}, {8{bwe[0]}}};
  assign wdata_s     = dataIn[15:0] & byte_mask_s;

  assign synced_s     = sync_r[SYNC_STAGES-1];
  assign rise_s       = synced_s & ~prev_r;
  assign ack_s        = (req_state_r == REQ) & interruptAcknowledge & (interruptOut == int_id_r);
  assign ack_onehot_s = ack_s ? (16'd1 << int_id_r) : 16'd0;
  assign eligible_s   = pending_r & enable_r & below_lowest(in_service_r);

  intc_priority_select u_select (
    .eligible (eligible_s),
    .valid    (sel_valid_s),
    .id       (sel_id_s)
  );

  // Synchroniser chain plus one history stage for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= 16'd0;
      end
      prev_r <= 16'd0;
    end else begin
      sync_r[0] <= irqSource & IMPL_MASK;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
      prev_r <= synced_s;
    end
  end

  // Register next-state: bus writes, source latching, ack set and EOI clear.
  always_comb begin
    w1c_s         = 16'd0;
    eoi_onehot_s  = 16'd0;
    enable_next_s = enable_r;
    edge_next_s   = edge_r;
    case (reg_idx_s)
      REG_PENDING: w1c_s = wr_s ? wdata_s : 16'd0;
      REG_ENABLE: begin
        if (wr_s) begin
          enable_next_s = ((enable_r & ~byte_mask_s) | wdata_s) & IMPL_MASK;
        end else begin
          enable_next_s = enable_r;
        end
      end
      REG_EDGE: begin
        if (wr_s) begin
          edge_next_s = ((edge_r & ~byte_mask_s) | wdata_s) & IMPL_MASK;
        end else begin
          edge_next_s = edge_r;
        end
      end
      REG_EOI: eoi_onehot_s = (wr_s & bwe[0]) ? (16'd1 << dataIn[3:0]) : 16'd0;
      default: w1c_s = 16'd0;
    endcase
    // Edge sources: a new rise beats both W1C and ack clear. Level sources track the line.
    pending_next_s = ((edge_r & ((pending_r & ~w1c_s & ~ack_onehot_s) | rise_s))
                    | (~edge_r & synced_s)) & IMPL_MASK;
    in_service_next_s = ((in_service_r & ~eoi_onehot_s) | ack_onehot_s) & IMPL_MASK;
  end

  // Request handshake next-state; the id is frozen once the request is raised.
  always_comb begin
    req_next_s = req_state_r;
    id_next_s  = int_id_r;
    case (req_state_r)
      IDLE: begin
        if (sel_valid_s) begin
          req_next_s = REQ;
          id_next_s  = sel_id_s;
        end else begin
          req_next_s = IDLE;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_next_s = ACK;
        end else begin
          req_next_s = REQ;
        end
      end
      ACK:     req_next_s = IDLE;
      default: req_next_s = IDLE;
    endcase
  end

  // Bus next-state and read-data mux.
  always_comb begin
    bus_next_s = bus_state_r;
    rd_data_s  = 16'd0;
    case (bus_state_r)
      BUS_IDLE: begin
        if (rd_s) begin
          bus_next_s = READ_RESP;
        end else begin
          bus_next_s = BUS_IDLE;
        end
      end
      READ_RESP: bus_next_s = BUS_IDLE;
      default:   bus_next_s = BUS_IDLE;
    endcase
    case (reg_idx_s)
      REG_PENDING:    rd_data_s = pending_r;
      REG_ENABLE:     rd_data_s = enable_r;
      REG_EDGE:       rd_data_s = edge_r;
      REG_IN_SERVICE: rd_data_s = in_service_r;
      REG_STATUS:     rd_data_s = {9'd0, req_state_r, int_id_r, req_r};
      default:        rd_data_s = 16'd0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r    <= 16'd0;
      enable_r     <= 16'd0;
      edge_r       <= 16'd0;
      in_service_r <= 16'd0;
      req_state_r  <= IDLE;
      bus_state_r  <= BUS_IDLE;
      int_id_r     <= 4'd0;
      req_r        <= 1'b0;
      read_valid_r <= 1'b0;
      data_out_r   <= 32'd0;
    end else begin
      pending_r    <= pending_next_s;
      enable_r     <= enable_next_s;
      edge_r       <= edge_next_s;
      in_service_r <= in_service_next_s;
      req_state_r  <= req_next_s;
      bus_state_r  <= bus_next_s;
      int_id_r     <= id_next_s;
      req_r        <= (req_next_s == REQ);
      read_valid_r <= rd_s;
      data_out_r   <= rd_s ? {16'd0, rd_data_s} : data_out_r;
    end
  end

  assign waitRequest      = wait_s;
  assign readValid        = read_valid_r;
  assign dataOut          = data_out_r;
  assign interruptRequest = req_r;
  assign interruptIn      = int_id_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0, write = 1'b0;
  logic [3:0]  bwe = 4'd0;
  logic [31:0] address = 32'd0, dataIn = 32'd0;
  logic        waitRequest, readValid;
  logic [31:0] dataOut;
  logic [15:0] irqSource = 16'd0;
  logic        interruptRequest;
  logic [3:0]  interruptIn;
  logic        interruptAcknowledge = 1'b0;
  logic [3:0]  interruptOut = 4'd0;

  int n_cmp = 0;
  int n_err = 0;

  interrupt_controller dut (
    .clk                  (clk),
    .reset                (reset),
    .read                 (read),
    .write                (write),
    .bwe                  (bwe),
    .address              (address),
    .dataIn               (dataIn),
    .waitRequest          (waitRequest),
    .readValid            (readValid),
    .dataOut              (dataOut),
    .irqSource            (irqSource),
    .interruptRequest     (interruptRequest),
    .interruptIn          (interruptIn),
    .interruptAcknowledge (interruptAcknowledge),
    .interruptOut         (interruptOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] idx, input logic [15:0] data, input logic [1:0] be);
    address = BASE | {27'd0, idx, 2'b00};
    dataIn  = {16'd0, data};
    bwe     = {2'b00, be};
    write   = 1'b1;
    tick();
    write   = 1'b0;
    bwe     = 4'd0;
  endtask

  task automatic bus_read(input logic [2:0] idx, input logic [31:0] exp, input string tag);
    address = BASE | {27'd0, idx, 2'b00};
    read    = 1'b1;
    tick();
    read    = 1'b0;
    check({tag, "_rv"}, {31'd0, readValid}, 32'd1);
    check(tag, dataOut, exp);
    tick();
  endtask

  task automatic do_ack(input logic [3:0] id);
    interruptAcknowledge = 1'b1;
    interruptOut         = id;
    tick();
    interruptAcknowledge = 1'b0;
  endtask

  task automatic check_req(input string tag, input logic req, input logic [3:0] id);
    check({tag, "_req"}, {31'd0, interruptRequest}, {31'd0, req});
    check({tag, "_id"}, {28'd0, interruptIn}, {28'd0, id});
  endtask

  initial begin
    // Reset state
    tick(3);
    reset = 1'b0;
    check("rst_rv", {31'd0, readValid}, 32'd0);
    check("rst_wait", {31'd0, waitRequest}, 32'd0);
    check("rst_dout", dataOut, 32'd0);
    check_req("rst", 1'b0, 4'd0);

    // Miss is ignored; byte enables; edge configuration
    address = 32'h0000_0004; dataIn = 32'h0000_FFFF; bwe = 4'b0011; write = 1'b1;
    tick();
    write = 1'b0; bwe = 4'd0;
    bus_read(3'd1, 32'h0000_0000, "miss_enable");
    bus_write(3'd1, 16'hFFFF, 2'b01);
    bus_read(3'd1, 32'h0000_00FF, "enable_lo");
    bus_write(3'd1, 16'hFFFF, 2'b10);
    bus_read(3'd1, 32'h0000_FFFF, "enable_all");
    bus_write(3'd2, 16'h00A4, 2'b11);
    bus_read(3'd2, 32'h0000_00A4, "edge_cfg");

    // Latency: pulse source 5
    irqSource = 16'h0020;
    tick();
    irqSource = 16'h0000;
    tick(2);
    check_req("lat3", 1'b0, 4'd0);
    tick();
    check_req("lat4", 1'b1, 4'd5);
    bus_read(3'd0, 32'h0000_0020, "pend5");
    bus_read(3'd5, 32'h0000_002B, "status_req5");

    // Mismatched ack ignored, matching ack retires
    do_ack(4'd4);
    check_req("bad_ack", 1'b1, 4'd5);
    do_ack(4'd5);
    check("ack_drop", {31'd0, interruptRequest}, 32'd0);
    tick();

    // Back-to-back reads: ENABLE then IN_SERVICE
    address = BASE | 32'h4; read = 1'b1;
    tick();
    address = BASE | 32'hC;
    #1;
    check("b2b_wait1", {31'd0, waitRequest}, 32'd1);
    check("b2b_rv1", {31'd0, readValid}, 32'd1);
    check("b2b_d1", dataOut, 32'h0000_FFFF);
    tick();
    check("b2b_wait2", {31'd0, waitRequest}, 32'd0);
    check("b2b_rv_gap", {31'd0, readValid}, 32'd0);
    tick();
    read = 1'b0;
    check("b2b_rv2", {31'd0, readValid}, 32'd1);
    check("b2b_d2", dataOut, 32'h0000_0020);
    tick();
    bus_read(3'd0, 32'h0000_0000, "pend_after_ack");

    // Nesting: 5 in service, raise 7 and 2
    irqSource = 16'h0084;
    tick();
    irqSource = 16'h0000;
    tick(3);
    check_req("nest_2", 1'b1, 4'd2);
    do_ack(4'd2);
    tick();
    bus_read(3'd3, 32'h0000_0024, "is_5_2");
    check("nest_7_blocked", {31'd0, interruptRequest}, 32'd0);
    bus_write(3'd4, 16'h0005, 2'b01);
    tick(2);
    check("eoi5_7_blocked", {31'd0, interruptRequest}, 32'd0);
    bus_write(3'd4, 16'h0002, 2'b01);
    tick();
    check_req("eoi2_7", 1'b1, 4'd7);
    do_ack(4'd7);
    tick();
    bus_read(3'd3, 32'h0000_0080, "is_7");
    bus_write(3'd4, 16'h0007, 2'b01);
    bus_read(3'd3, 32'h0000_0000, "is_clear");
    bus_read(3'd0, 32'h0000_0000, "pend_clear");

    // W1C on an edge source
    bus_write(3'd1, 16'h0000, 2'b11);
    irqSource = 16'h0020;
    tick();
    irqSource = 16'h0000;
    tick(3);
    bus_read(3'd0, 32'h0000_0020, "edge_pend");
    bus_write(3'd0, 16'h0020, 2'b01);
    bus_read(3'd0, 32'h0000_0000, "edge_w1c");

    // Level source 3 ignores W1C and follows the line
    bus_write(3'd1, 16'hFFF7, 2'b11);
    irqSource = 16'h0008;
    tick(4);
    bus_read(3'd0, 32'h0000_0008, "lvl_pend");
    bus_write(3'd0, 16'h0008, 2'b01);
    bus_read(3'd0, 32'h0000_0008, "lvl_w1c");
    check("lvl_disabled", {31'd0, interruptRequest}, 32'd0);
    irqSource = 16'h0000;
    tick(4);
    bus_read(3'd0, 32'h0000_0000, "lvl_drop");
    bus_write(3'd1, 16'hFFFF, 2'b11);

    // Reserved register drops writes
    bus_write(3'd6, 16'hFFFF, 2'b11);
    bus_read(3'd6, 32'h0000_0000, "reserved");

    // Reset while in REQ
    irqSource = 16'h0001;
    tick(5);
    check_req("pre_rst", 1'b1, 4'd0);
    reset = 1'b1;
    tick();
    check("rst_req", {31'd0, interruptRequest}, 32'd0);
    irqSource = 16'h0000;
    tick(2);
    reset = 1'b0;
    for (int r = 0; r < 6; r++) begin
      bus_read(3'(r), 32'h0000_0000, "post_rst_reg");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
